// File: rtl/cpu_pkg.sv
// Shared types for the execute controller: instruction layout, ALU opcodes, FSM states.
// Optional feature macro used by exec_ctrl: EXEC_CTRL_ZFLAG_EN.
package cpu_pkg;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int RD_MSB   = 12;
    localparam int RD_LSB   = 11;
    localparam int RS_MSB   = 10;
    localparam int RS_LSB   = 9;
    localparam int UIMM_BIT = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_NOT = 3'b011,
        ALU_SHR = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_XOR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } exec_state_e;

    typedef struct packed {
        alu_op_e    op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       use_imm;
        logic [7:0] imm;
    } instr_t;

endpackage

// File: rtl/exec_regfile.sv
// Register file: NREG x WIDTH, two async read ports, one sync write port.
// Whole array clears on async active-low reset.
module exec_regfile
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       raddr_a_i,
    input  logic [1:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic             we_i,
    input  logic [1:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i
);

    logic [WIDTH-1:0] mem_q [NREG];

    // Storage: clear on reset, write one entry when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/exec_ctrl.sv
// Execute controller: accepts one instruction, reads operands, drives the ALU, writes back.
// Optional zero flag is built only when EXEC_CTRL_ZFLAG_EN is defined.
module exec_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    output logic [1:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             zflag
);

    exec_state_e      state_q, state_d;
    instr_t           instr_q;
    logic             ready_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    alu_op_e          alu_op_q;
    logic             wb_valid_q;
    logic [1:0]       wb_rd_q;
    logic [WIDTH-1:0] wb_data_q;
    logic [WIDTH-1:0] rdata_a, rdata_b;
    logic             hs;
    logic             rf_we;

    assign hs    = instr_valid & ready_q;
    assign rf_we = (state_q == ST_EXEC);

    exec_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (instr_q.rd),
        .raddr_b_i (instr_q.rs),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (rf_we),
        .waddr_i   (instr_q.rd),
        .wdata_i   (alu_result)
    );

    // Next state: only IDLE waits on the handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (hs) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered ready (high exactly while in IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Instruction latch and ALU operand registers (held outside READ).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALU_ADD;
        end else begin
            if (hs) begin
                instr_q <= instr_t'(instr);
            end
            if (state_q == ST_READ) begin
                alu_a_q  <= rdata_a;
                alu_b_q  <= instr_q.use_imm ? WIDTH'(instr_q.imm) : rdata_b;
                alu_op_q <= instr_q.op;
            end
        end
    end

    // Writeback registers: captured on the EXEC->WB edge, pulse lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= (state_q == ST_EXEC);
            if (state_q == ST_EXEC) begin
                wb_rd_q   <= instr_q.rd;
                wb_data_q <= alu_result;
            end
        end
    end

`ifdef EXEC_CTRL_ZFLAG_EN
    logic zflag_q;

    // Zero flag of the last written result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zflag_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            zflag_q <= (alu_result == '0);
        end
    end

    assign zflag = zflag_q;
`else
    assign zflag = 1'b0;
`endif

    assign instr_ready = ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed self-checking bench for exec_ctrl with a behavioural ALU stub.
// Zero-flag expectations follow EXEC_CTRL_ZFLAG_EN.
module tb_exec_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [15:0]      instr;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_op;
    logic             wb_valid;
    logic [1:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             zflag;

    int n_chk  = 0;
    int n_fail = 0;
    int wb_cnt = 0;
    logic [WIDTH-1:0] ex_a, ex_b;
    logic [2:0]       ex_op;
    logic [11:0]      rdy_v, wbv_v;
    logic [WIDTH-1:0] wbd_last;
    int               cnt_save;
    logic             zexp1;

    exec_ctrl #(.WIDTH(WIDTH), .NREG(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .zflag       (zflag)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a * alu_b;
            3'b011: alu_result = ~alu_a;
            3'b100: alu_result = alu_a >> 1;
            3'b101: alu_result = alu_a & alu_b;
            3'b110: alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    always @(negedge clk) if (wb_valid === 1'b1) wb_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge with the DUT idle; returns after the WB cycle.
    task automatic run(input string tag, input logic [2:0] op,
                       input logic [1:0] rd, input logic [1:0] rs,
                       input logic ui, input logic [7:0] imm,
                       input logic [7:0] exp);
        int n;
        instr       = {op, rd, rs, ui, imm};
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_hs_timeout"}, 32'(n < 20), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        check({tag, "_rd_nowb"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
        ex_a  = alu_a;
        ex_b  = alu_b;
        ex_op = alu_op;
        check({tag, "_ex_nowb"}, 32'(wb_valid), 32'd0);
        @(negedge clk);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        check({tag, "_wb_data"}, 32'(wb_data), 32'(exp));
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(instr_ready), 32'd1);
        check({tag, "_wb_drop"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
`ifdef EXEC_CTRL_ZFLAG_EN
        zexp1 = 1'b1;
`else
        zexp1 = 1'b0;
`endif
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd0);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        check("rst_zflag", 32'(zflag), 32'd0);
        check("rst_alu", {alu_op, 5'd0, alu_a, alu_b, wb_data}, 32'd0);
        check("rst_wbrd", 32'(wb_rd), 32'd0);
        rst_n = 1'b1;
        #1 check("rel_ready0", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("rel_ready1", 32'(instr_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("idle_nowb", 32'(wb_cnt), 32'd0);
        check("idle_ready", 32'(instr_ready), 32'd1);

        run("add5", 3'b000, 2'd1, 2'd0, 1'b1, 8'd5, 8'h05);
        run("add250", 3'b000, 2'd1, 2'd0, 1'b1, 8'd250, 8'hFF);
        check("z_ff", 32'(zflag), 32'd0);
        run("add1", 3'b000, 2'd1, 2'd0, 1'b1, 8'd1, 8'h00);
        check("z_00", 32'(zflag), 32'(zexp1));
        repeat (2) @(negedge clk);
        check("z_hold", 32'(zflag), 32'(zexp1));
        check("idle_hold", {alu_a, alu_b, 5'd0, alu_op, wb_data}, {8'hFF, 8'd1, 8'd0, 8'h00});

        run("r2_12", 3'b000, 2'd2, 2'd0, 1'b1, 8'd12, 8'd12);
        run("r3_20", 3'b000, 2'd3, 2'd0, 1'b1, 8'd20, 8'd20);
        run("mul", 3'b010, 2'd2, 2'd3, 1'b0, 8'h00, 8'd240);
        check("mul_ex_a", 32'(ex_a), 32'd12);
        check("mul_ex_b", 32'(ex_b), 32'd20);
        check("mul_ex_op", 32'(ex_op), 32'd2);
        check("mul_z", 32'(zflag), 32'd0);
        run("sub", 3'b001, 2'd3, 2'd2, 1'b0, 8'h00, 8'h24);
        run("same", 3'b000, 2'd2, 2'd2, 1'b0, 8'h00, 8'hE0);
        check("same_ab", {ex_a, ex_b}, {8'd240, 8'd240});
        run("and", 3'b101, 2'd3, 2'd0, 1'b1, 8'h0F, 8'h04);
        run("not", 3'b011, 2'd3, 2'd1, 1'b1, 8'h55, 8'hFB);
        check("not_fwd_b", 32'(ex_b), 32'h55);

        instr       = {3'b000, 2'd0, 2'd0, 1'b1, 8'd1};
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rdy_v[k] = instr_ready;
            wbv_v[k] = wb_valid;
            if (k == 11) begin
                wbd_last    = wb_data;
                instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_ready", 32'(rdy_v), 32'h111);
        check("stream_wbv", 32'(wbv_v), 32'h888);
        check("stream_r0", 32'(wbd_last), 32'd3);
        check("stream_idle", 32'(instr_ready), 32'd1);

        instr       = {3'b000, 2'd0, 2'd0, 1'b1, 8'd7};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        cnt_save = wb_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(instr_ready), 32'd0);
        check("abort_alu", {alu_a, alu_b, 5'd0, alu_op}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_nowb", 32'(wb_cnt), 32'(cnt_save));
        check("abort_ready1", 32'(instr_ready), 32'd1);
        run("r0_chk", 3'b000, 2'd0, 2'd0, 1'b1, 8'd0, 8'd0);
        run("r2_chk", 3'b110, 2'd2, 2'd0, 1'b1, 8'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath and register width.
REQ-002 SHALL have parameter NREG, default 4: register-file depth; fixed at 4 because the rd/rs fields are 2 bits.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port instr_valid  input  1: upstream presents an instruction.
REQ-006 SHALL have port instr_ready  output  1: block can accept an instruction.
REQ-007 SHALL have port instr  input  16: instruction word; [15:13] op, [12:11] rd, [10:9] rs, [8] use_imm, [7:0] imm.
REQ-008 SHALL have port alu_a  output  WIDTH: ALU operand a.
REQ-009 SHALL have port alu_b  output  WIDTH: ALU operand b.
REQ-010 SHALL have port alu_op  output  3: ALU opcode (000 ADD, 001 SUB, 010 MUL, 011 NOT, 100 SHR, 101 AND, 110 OR, 111 XOR).
REQ-011 SHALL have port alu_result  input  WIDTH: combinational result from the ALU.
REQ-012 SHALL have port wb_valid  output  1: one-cycle pulse marking a register write.
REQ-013 SHALL have port wb_rd  output  2: destination register of the write.
REQ-014 SHALL have port wb_data  output  WIDTH: value written.
REQ-015 SHALL have port zflag  output  1: zero flag of the last result.

Function
REQ-016 SHALL implement FSM states IDLE, READ, EXEC, WB; transitions are IDLE->READ on handshake, READ->EXEC, EXEC->WB, WB->IDLE, all unconditional except the first.
REQ-017 SHALL define the handshake as instr_valid & instr_ready at a rising edge; instr is latched at that edge.
REQ-018 SHALL assert instr_ready, as a register, only while state is IDLE; instr is ignored otherwise.
REQ-019 SHALL, in READ, register alu_a = R[rd] and alu_b = use_imm ? imm[WIDTH-1:0] : R[rs], and register alu_op = op, all taking effect at the READ->EXEC edge.
REQ-020 SHALL hold alu_a/alu_b/alu_op stable from EXEC through WB.
REQ-021 SHALL, at the EXEC->WB edge, capture alu_result into wb_data, write it into R[rd], load wb_rd, and set wb_valid.
REQ-022 SHALL pulse wb_valid high for exactly the WB cycle, i.e. 3 cycles after the handshake edge; the next handshake is possible 4 cycles after the previous one.
REQ-023 SHALL treat all arithmetic as modulo 2^WIDTH; the ALU truncates, and the block performs no width extension.
REQ-024 SHALL, when rd == rs, read the old R[rd] for both operands.
REQ-025 SHALL forward the b operand even for NOT/SHR; the ALU ignores it.
REQ-026 SHALL hold alu_* and wb_rd/wb_data at their last values in IDLE.

Reset
REQ-027 SHALL, on rst_n low at any time, immediately force: state IDLE; instr_ready, wb_valid, zflag 0; alu_a, alu_b, alu_op, wb_rd, wb_data 0; all R[i] 0.
REQ-028 SHALL raise instr_ready on the first clock edge after rst_n deasserts.
REQ-029 SHALL, if reset occurs mid-instruction, abort it: no register write, no wb_valid.

Configuration
REQ-030 SHALL, with EXEC_CTRL_ZFLAG_EN defined, set zflag at the EXEC->WB edge to (alu_result == 0) and hold it until the next write.
REQ-031 SHALL, without EXEC_CTRL_ZFLAG_EN, tie zflag to constant 0 with no flop present.

Structure
REQ-032 SHALL place alu_op_e (3-bit enum), exec_state_e, the instr field positions, and the instr_t packed struct in a shared package cpu_pkg.
REQ-033 SHALL implement the register file as sub-module exec_regfile: NREG x WIDTH, 2 asynchronous read ports, 1 synchronous write port, async active-low reset to 0.

Verification
REQ-034 SHALL cover: reset then idle -> instr_ready 0 during reset, 1 one edge after release, wb_valid never pulses.
REQ-035 SHALL cover: ADD R1,#5 then ADD R1,#250 -> first wb R1=5; second wb R1=255 (0xFF), zflag=0.
REQ-036 SHALL cover: R1=255, ADD R1,#1 -> wb_data 0x00, zflag=1 (with macro) / 0 (without).
REQ-037 SHALL cover: R2=12, R3=20, MUL R2,R3 (rs=3) -> alu_a 12, alu_b 20 in EXEC, wb R2=240; then SUB R3,R2 -> R3=0x24.
REQ-038 SHALL cover: instr_valid held high continuously -> handshakes exactly every 4 cycles, wb_valid exactly 3 cycles after each.
REQ-039 SHALL cover: rst_n pulsed low during EXEC of ADD R0,#7 -> no wb_valid, R0 stays 0.
